dht_sensor_emulator: RTL and testbench

- Device side of the single-wire DHT11-style humidity/temperature protocol. It acts as the sensor on the shared open-drain DHT_DATA line.
- Detects the host start pulse, sends the presence/ack sequence, then serialises a 40-bit frame: humidity int, humidity frac, temperature int, temperature frac, checksum.
- Used as an on-board/bench stand-in for the physical sensor so the host decoder can be exercised without hardware.

---
 rtl/dht_pkg.sv | 40 ++++
 rtl/dht_bus_io.sv | 26 ++
 rtl/dht_sensor_emulator.sv | 171 +++++++++++++++++
 tb/tb_dht_sensor_emulator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// Shared types, protocol timing (microseconds) and checksum helper for the
// DHT11-style sensor emulator.
`timescale 1ns/1ps
package dht_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_RESP_WAIT,
    ST_ACK_LOW,
    ST_ACK_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW
  } dht_state_t;

  localparam int unsigned DHT_CLK_MHZ       = 50;
  localparam int unsigned DHT_START_MIN_US  = 10000;
  localparam int unsigned DHT_RESP_DELAY_US = 30;
  localparam int unsigned DHT_ACK_LOW_US    = 80;
  localparam int unsigned DHT_ACK_HIGH_US   = 80;
  localparam int unsigned DHT_BIT_LOW_US    = 50;
  localparam int unsigned DHT_T0_HIGH_US    = 26;
  localparam int unsigned DHT_T1_HIGH_US    = 70;

  localparam int unsigned DHT_FRAME_BITS  = 40;
  localparam int unsigned DHT_FRAME_BYTES = 5;
  localparam int unsigned DHT_CNT_W       = 24;
  // A low seen on line_s only counts as a foreign driver once our own
  // release has had time to propagate through the synchronizer.
  localparam int unsigned DHT_SYNC_GUARD  = 3;

  typedef logic [DHT_FRAME_BYTES-1:0][7:0] dht_frame_t;

  function automatic logic [7:0] dht_checksum(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/dht_bus_io.sv
// Open-drain pin driver and 2-FF input synchronizer for the DHT data line.
`timescale 1ns/1ps
module dht_bus_io (
  input  logic CLK,
  input  logic RST,
  input  logic drive_low,
  inout  wire  line,
  output logic line_s
);

  logic sync1;

  assign line = drive_low ? 1'b0 : 1'bz;

  // Reset to the idle (pulled-up) level so no phantom start is seen.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1  <= 1'b1;
      line_s <= 1'b1;
    end else begin
      sync1  <= line;
      line_s <= sync1;
    end
  end

endmodule

// File: rtl/dht_sensor_emulator.sv
// Device side of the DHT11 single-wire protocol: detects the host start
// pulse, acknowledges, then sends a latched 40-bit humidity/temperature frame.
`timescale 1ns/1ps
module dht_sensor_emulator
  import dht_pkg::*;
#(
  parameter int unsigned CLK_MHZ       = DHT_CLK_MHZ,
  parameter int unsigned START_MIN_US  = DHT_START_MIN_US,
  parameter int unsigned RESP_DELAY_US = DHT_RESP_DELAY_US,
  parameter int unsigned ACK_LOW_US    = DHT_ACK_LOW_US,
  parameter int unsigned ACK_HIGH_US   = DHT_ACK_HIGH_US,
  parameter int unsigned BIT_LOW_US    = DHT_BIT_LOW_US,
  parameter int unsigned T0_HIGH_US    = DHT_T0_HIGH_US,
  parameter int unsigned T1_HIGH_US    = DHT_T1_HIGH_US,
  parameter int unsigned MSB_FIRST     = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  inout  wire        DHT_DATA,
  input  logic [7:0] HUM_INT,
  input  logic [7:0] HUM_FLOAT,
  input  logic [7:0] TEMP_INT,
  input  logic [7:0] TEMP_FLOAT,
  input  logic       CRC_CORRUPT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [5:0] BIT_IDX
);

  typedef logic [DHT_CNT_W-1:0] cnt_t;

  localparam cnt_t START_MIN_CYC = cnt_t'(START_MIN_US * CLK_MHZ);
  localparam cnt_t RESP_LAST     = cnt_t'(RESP_DELAY_US * CLK_MHZ - 1);
  localparam cnt_t ACK_LOW_LAST  = cnt_t'(ACK_LOW_US * CLK_MHZ - 1);
  localparam cnt_t ACK_HIGH_LAST = cnt_t'(ACK_HIGH_US * CLK_MHZ - 1);
  localparam cnt_t BIT_LOW_LAST  = cnt_t'(BIT_LOW_US * CLK_MHZ - 1);
  localparam cnt_t T0_LAST       = cnt_t'(T0_HIGH_US * CLK_MHZ - 1);
  localparam cnt_t T1_LAST       = cnt_t'(T1_HIGH_US * CLK_MHZ - 1);
  localparam cnt_t GUARD_CYC     = cnt_t'(DHT_SYNC_GUARD);
  localparam logic [5:0] LAST_BIT = 6'(DHT_FRAME_BITS - 1);

  dht_state_t state_q, state_d;
  cnt_t       cnt_q;
  logic       drive_low_q;
  logic       done_q, error_q;
  logic       line_s;
  dht_frame_t shadow_q;

  logic       latch, abort, frame_end;
  logic       contention;
  logic       cur_bit;
  logic [2:0] byte_sel, bit_pos;
  logic [7:0] crc;

  dht_bus_io u_bus_io (
    .CLK       (CLK),
    .RST       (RST),
    .drive_low (drive_low_q),
    .line      (DHT_DATA),
    .line_s    (line_s)
  );

  assign crc        = dht_checksum(HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT) ^ {8{CRC_CORRUPT}};
  assign contention = !line_s && (cnt_q >= GUARD_CYC);
  assign byte_sel   = BIT_IDX[5:3];
  assign bit_pos    = (MSB_FIRST != 0) ? (3'd7 - BIT_IDX[2:0]) : BIT_IDX[2:0];
  assign cur_bit    = shadow_q[byte_sel][bit_pos];

  assign BUSY  = !(state_q inside {ST_IDLE, ST_HOST_LOW});
  assign DONE  = done_q;
  assign ERROR = error_q;

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    abort     = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!line_s) state_d = ST_HOST_LOW;
      end
      ST_HOST_LOW: begin
        if (line_s) begin
          if (cnt_q >= START_MIN_CYC) begin
            state_d = ST_RESP_WAIT;
            latch   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESP_WAIT: begin
        if (contention) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else if (cnt_q >= RESP_LAST) begin
          state_d = ST_ACK_LOW;
        end
      end
      ST_ACK_LOW: begin
        if (cnt_q >= ACK_LOW_LAST) state_d = ST_ACK_HIGH;
      end
      ST_ACK_HIGH: begin
        if (contention) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else if (cnt_q >= ACK_HIGH_LAST) begin
          state_d = ST_BIT_LOW;
        end
      end
      ST_BIT_LOW: begin
        if (cnt_q >= BIT_LOW_LAST) state_d = ST_BIT_HIGH;
      end
      ST_BIT_HIGH: begin
        if (contention) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else if (cnt_q >= (cur_bit ? T1_LAST : T0_LAST)) begin
          state_d = (BIT_IDX == LAST_BIT) ? ST_END_LOW : ST_BIT_LOW;
        end
      end
      ST_END_LOW: begin
        if (cnt_q >= BIT_LOW_LAST) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!EN) begin
      state_d   = ST_IDLE;
      latch     = 1'b0;
      abort     = 1'b0;
      frame_end = 1'b0;
    end
  end

  // drive_low is derived from the next state so the pin tracks state_q exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      drive_low_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      BIT_IDX     <= '0;
      shadow_q    <= '0;
    end else begin
      state_q     <= state_d;
      drive_low_q <= state_d inside {ST_ACK_LOW, ST_BIT_LOW, ST_END_LOW};
      done_q      <= frame_end;
      error_q     <= abort;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + cnt_t'(1);
      end
      if (latch) begin
        shadow_q <= {crc, TEMP_FLOAT, TEMP_INT, HUM_FLOAT, HUM_INT};
      end
      if (state_q == ST_ACK_HIGH && state_d == ST_BIT_LOW) begin
        BIT_IDX <= '0;
      end else if (state_q == ST_BIT_HIGH && state_d == ST_BIT_LOW) begin
        BIT_IDX <= BIT_IDX + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_dht_sensor_emulator.sv
// Self-checking bench: acts as host on the open-drain line and checks every
// pulse width the sensor produces against a segment-level protocol model.
`timescale 1ns/1ps
module tb_dht_sensor_emulator;

  // One clock per microsecond keeps every phase short but protocol-exact.
  localparam int START_MIN = 2000;
  localparam int START_LEN = 2200;
  localparam int SHORT_LEN = 1000;
  localparam int RESP      = 30;
  localparam int ACK_L     = 80;
  localparam int ACK_H     = 80;
  localparam int BIT_L     = 50;
  localparam int T0        = 26;
  localparam int T1        = 70;
  localparam int SYNC_LAT  = 3;
  localparam int TOL       = 2;

  typedef struct {
    logic lvl;
    int   len;
    int   bitno;
  } seg_t;

  logic clk = 1'b0;
  logic rst, en;
  logic host_low = 1'b0, ext_low = 1'b0;
  logic [7:0] hum_int, hum_float, temp_int, temp_float;
  logic crc_corrupt;
  logic busy, done, error;
  logic [5:0] bit_idx;
  wire  dht_data;

  pullup pu (dht_data);
  assign dht_data = (host_low || ext_low) ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  dht_sensor_emulator #(
    .CLK_MHZ      (1),
    .START_MIN_US (START_MIN)
  ) u_dut (
    .CLK         (clk),
    .RST         (rst),
    .EN          (en),
    .DHT_DATA    (dht_data),
    .HUM_INT     (hum_int),
    .HUM_FLOAT   (hum_float),
    .TEMP_INT    (temp_int),
    .TEMP_FLOAT  (temp_float),
    .CRC_CORRUPT (crc_corrupt),
    .BUSY        (busy),
    .DONE        (done),
    .ERROR       (error),
    .BIT_IDX     (bit_idx)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0, err_cnt = 0, busy_cyc = 0, low_cyc = 0, seg_no = 0;
  int   exp_busy = 0;
  seg_t seg_q[$];
  logic dec_bits [40];
  logic prev_lvl = 1'b1;
  int   run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp);
    n_checks++;
    if (act < exp - TOL || act > exp + TOL) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d +/-%0d", name, act, exp, TOL);
    end
  endtask

  // Compare process: every completed line segment is checked against the model.
  always @(negedge clk) begin : monitor
    logic cur;
    seg_t s;
    cur = dht_data;
    if (done)  done_cnt++;
    if (error) err_cnt++;
    if (busy)  busy_cyc++;
    if (cur === 1'b0) low_cyc++;
    if (cur !== prev_lvl) begin
      if (seg_q.size() != 0) begin
        s = seg_q.pop_front();
        seg_no++;
        n_checks++;
        if (prev_lvl !== s.lvl || run < s.len - TOL || run > s.len + TOL) begin
          n_errors++;
          $display("FAIL segment %0d: level %0b for %0d cycles, expected level %0b for %0d",
                   seg_no, prev_lvl, run, s.lvl, s.len);
        end
        if (s.bitno >= 0) dec_bits[s.bitno] = (run > (T0 + T1) / 2);
      end
      prev_lvl = cur;
      run = 1;
    end else begin
      run++;
    end
  end

  function automatic logic [7:0] dec_byte(input int k);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[j] = dec_bits[k * 8 + j];
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    done_cnt = 0; err_cnt = 0; busy_cyc = 0; low_cyc = 0; seg_no = 0;
    for (int i = 0; i < 40; i++) dec_bits[i] = 1'bx;
  endtask

  // Model: expected (level, length) segments from the frame contents.
  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic corrupt, input int nfull,
                            input int host_len);
    int by [5];
    int sum;
    int hi;
    sum   = (int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256;
    by[0] = int'(b0); by[1] = int'(b1); by[2] = int'(b2); by[3] = int'(b3);
    by[4] = corrupt ? 255 - sum : sum;
    seg_q.push_back('{1'b0, host_len, -1});
    seg_q.push_back('{1'b1, RESP + SYNC_LAT, -1});
    seg_q.push_back('{1'b0, ACK_L, -1});
    seg_q.push_back('{1'b1, ACK_H, -1});
    exp_busy = RESP + ACK_L + ACK_H + BIT_L;
    for (int i = 0; i < nfull; i++) begin
      hi = (((by[i / 8] >> (i % 8)) & 1) != 0) ? T1 : T0;
      seg_q.push_back('{1'b0, BIT_L, -1});
      seg_q.push_back('{1'b1, hi, i});
      exp_busy += BIT_L + hi;
    end
    seg_q.push_back('{1'b0, BIT_L, -1});
  endtask

  task automatic start_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic corrupt, input int nfull,
                             input int host_len, input logic model);
    hum_int = b0; hum_float = b1; temp_int = b2; temp_float = b3; crc_corrupt = corrupt;
    cyc(1);
    host_low = 1'b1;
    cyc(2);
    if (model) push_frame(b0, b1, b2, b3, corrupt, nfull, host_len);
    cyc(host_len - 2);
    host_low = 1'b0;
  endtask

  task automatic wait_segs(input int budget, input string name);
    int k = 0;
    while (seg_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(seg_q.size()), 32'd0);
    seg_q.delete();
  endtask

  task automatic wait_bit(input int idx, input logic lvl, input int budget, input string name);
    int k = 0;
    while (!(bit_idx == 6'(idx) && dht_data === lvl) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(k < budget), 32'd1);
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    chk({tag, " hum_int"},    32'(dec_byte(0)), 32'(e0));
    chk({tag, " hum_float"},  32'(dec_byte(1)), 32'(e1));
    chk({tag, " temp_int"},   32'(dec_byte(2)), 32'(e2));
    chk({tag, " temp_float"}, 32'(dec_byte(3)), 32'(e3));
    chk({tag, " crc"},        32'(dec_byte(4)), 32'(e4));
    chk({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, " error pulses"}, 32'(err_cnt), 32'd0);
    chk({tag, " bit_idx"}, 32'(bit_idx), 32'd39);
    chk({tag, " busy low"}, 32'(busy), 32'd0);
    chk_near({tag, " busy cycles"}, busy_cyc, exp_busy);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1;
    hum_int = '0; hum_float = '0; temp_int = '0; temp_float = '0; crc_corrupt = 1'b0;
    cyc(5);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset error", 32'(error), 32'd0);
    chk("reset bit_idx", 32'(bit_idx), 32'd0);
    chk("reset line", 32'(dht_data), 32'd1);
    rst = 1'b0;
    cyc(5);

    // Nominal frame.
    clear_counts();
    start_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 40, START_LEN, 1'b1);
    wait_segs(6000, "frame1 complete");
    cyc(5);
    chk_frame("frame1", 8'h37, 8'h00, 8'h19, 8'h05, 8'h55);

    // Short host pulse is ignored.
    clear_counts();
    start_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 0, SHORT_LEN, 1'b0);
    low_cyc = 0; busy_cyc = 0;
    cyc(300);
    chk("short pulse line activity", 32'(low_cyc), 32'd0);
    chk("short pulse busy", 32'(busy_cyc), 32'd0);

    // Corrupted checksum.
    clear_counts();
    start_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 40, START_LEN, 1'b1);
    wait_segs(6000, "crc frame complete");
    cyc(5);
    chk_frame("crc frame", 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5);

    // Foreign driver during bit 12 high phase.
    clear_counts();
    start_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 12, START_LEN, 1'b1);
    wait_bit(12, 1'b1, 3000, "reach bit12 high");
    seg_q.push_back('{1'b1, 20, -1});
    seg_q.push_back('{1'b0, 10, -1});
    repeat (20) @(posedge clk);
    #1;
    ext_low = 1'b1;
    cyc(10);
    ext_low = 1'b0;
    wait_segs(100, "contention segments");
    cyc(5);
    chk("contention error pulses", 32'(err_cnt), 32'd1);
    chk("contention done pulses", 32'(done_cnt), 32'd0);
    chk("contention busy", 32'(busy), 32'd0);
    chk("contention line released", 32'(dht_data), 32'd1);

    // Reset in the middle of bit 20, then a fresh full frame.
    clear_counts();
    start_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 0, START_LEN, 1'b0);
    wait_bit(20, 1'b0, 3000, "reach bit20 low");
    chk("pre-reset line low", 32'(dht_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid reset line", 32'(dht_data), 32'd1);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset done", 32'(done), 32'd0);
    chk("mid reset error", 32'(error), 32'd0);
    chk("mid reset bit_idx", 32'(bit_idx), 32'd0);
    rst = 1'b0;
    cyc(5);
    clear_counts();
    start_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 40, START_LEN, 1'b1);
    wait_segs(6000, "post-reset frame complete");
    cyc(5);
    chk_frame("post-reset frame", 8'h12, 8'h34, 8'h56, 8'h78, 8'h14);

    // Inputs change after the frame is latched.
    clear_counts();
    start_frame(8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b0, 40, START_LEN, 1'b1);
    wait_bit(8, 1'b0, 3000, "reach bit8 low");
    hum_int = 8'h55; hum_float = 8'h55; temp_int = 8'h55; temp_float = 8'h55; crc_corrupt = 1'b1;
    wait_segs(6000, "latched frame complete");
    cyc(5);
    chk_frame("latched frame", 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hA8);

    // EN dropped mid-frame.
    clear_counts();
    start_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 0, START_LEN, 1'b0);
    wait_bit(3, 1'b0, 3000, "reach bit3 low");
    @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("en low line", 32'(dht_data), 32'd1);
    chk("en low busy", 32'(busy), 32'd0);
    cyc(5);
    en = 1'b1;
    cyc(100);
    chk("en low done pulses", 32'(done_cnt), 32'd0);
    chk("en low error pulses", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
